serial_frame_collector: RTL and testbench

//  Downstream consumer of the 1-bit registered data stream (q) produced by the

---
 rtl/serial_frame_collector.sv | 117 +++++++++++
 tb/tb_serial_frame_collector.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_collector.sv
// serial_frame_collector
// Hunts a serial bit stream for a fixed header and then gathers the next
// WIDTH bits, MSB first, into a payload word. A single output holding
// register presents completed words on a valid/ready handshake. Frames that
// complete while the holding register is still occupied are dropped and
// flagged on a sticky overflow bit.

module serial_frame_collector #(
    parameter int                 WIDTH   = 8,
    parameter int                 HDR_LEN = 4,
    parameter logic [HDR_LEN-1:0] HEADER  = 4'b1011
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             d,
    input  logic             en,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] word,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             overflow,
    output logic             busy
);

    localparam int HCW = $clog2(HDR_LEN + 1);
    localparam int BCW = $clog2(WIDTH);

    typedef enum logic {
        HUNT,
        COLLECT
    } state_t;

    state_t             state;
    logic [HDR_LEN-1:0] hdr_sr;
    logic [HCW-1:0]     hunt_cnt;
    logic [BCW-1:0]     bit_cnt;
    logic [WIDTH-1:0]   payload;

    logic [HDR_LEN-1:0] hdr_next;
    logic [HCW-1:0]     hunt_next;
    logic               hdr_hit;
    logic [WIDTH-1:0]   pay_next;
    logic               last_bit;
    logic               frame_done;
    logic               transfer;
    logic               drop;

    // Next-value shift registers, header match and handshake decode
    always_comb begin
        hdr_next   = HDR_LEN'({hdr_sr, d});
        hunt_next  = (hunt_cnt == HCW'(HDR_LEN)) ? hunt_cnt : hunt_cnt + 1'b1;
        hdr_hit    = (hdr_next == HEADER) && (hunt_next == HCW'(HDR_LEN));
        pay_next   = WIDTH'({payload, d});
        last_bit   = (bit_cnt == BCW'(WIDTH - 1));
        frame_done = (state == COLLECT) && en && last_bit;
        transfer   = word_valid && word_ready;
        drop       = frame_done && word_valid && !word_ready;
    end

    // Hunt/collect state machine; every register holds while en is low
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= HUNT;
            hdr_sr   <= '0;
            hunt_cnt <= '0;
            bit_cnt  <= '0;
            payload  <= '0;
        end else if (en) begin
            case (state)
                HUNT: begin
                    if (hdr_hit) begin
                        state    <= COLLECT;
                        hdr_sr   <= '0;
                        hunt_cnt <= '0;
                    end else begin
                        hdr_sr   <= hdr_next;
                        hunt_cnt <= hunt_next;
                    end
                end
                COLLECT: begin
                    payload <= pay_next;
                    if (last_bit) begin
                        bit_cnt <= '0;
                        state   <= HUNT;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: state <= HUNT;
            endcase
        end
    end

    // Output holding register: load on completion if free or being drained
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            word       <= '0;
            word_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (frame_done && (!word_valid || transfer)) begin
                word       <= pay_next;
                word_valid <= 1'b1;
            end else if (transfer) begin
                word_valid <= 1'b0;
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    assign busy = (state == COLLECT);

endmodule

// File: tb/tb_serial_frame_collector.sv
// tb_serial_frame_collector
// Directed test of serial_frame_collector. Expected payload words are queued
// when a frame is driven and compared when the DUT hands a word over.

module tb_serial_frame_collector;

    logic       clk;
    logic       rstn;
    logic       d;
    logic       en;
    logic       clr_ovf;
    logic [7:0] word;
    logic       word_valid;
    logic       word_ready;
    logic       overflow;
    logic       busy;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] sb_q[$];

    serial_frame_collector #(
        .WIDTH  (8),
        .HDR_LEN(4),
        .HEADER (4'b1011)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .d         (d),
        .en        (en),
        .clr_ovf   (clr_ovf),
        .word      (word),
        .word_valid(word_valid),
        .word_ready(word_ready),
        .overflow  (overflow),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Compare one observed value against the bench's expectation
    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs and wait until just after the next rising edge
    task automatic apply_stimulus(input logic dv, input logic env, input logic rdy, input logic clr);
        d          = dv;
        en         = env;
        word_ready = rdy;
        clr_ovf    = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic send_header();
        apply_stimulus(1'b1, 1'b1, word_ready, 1'b0);
        apply_stimulus(1'b0, 1'b1, word_ready, 1'b0);
        apply_stimulus(1'b1, 1'b1, word_ready, 1'b0);
        apply_stimulus(1'b1, 1'b1, word_ready, 1'b0);
    endtask

    task automatic send_bits(input logic [7:0] w, input int n, input logic rdy);
        for (int i = 7; i > 7 - n; i--) begin
            apply_stimulus(w[i], 1'b1, rdy, 1'b0);
        end
    endtask

    // Scoreboard: each word handed over must match the oldest queued frame
    always @(negedge clk) begin
        if (rstn && word_valid && word_ready) begin
            checks++;
            assert (sb_q.size() > 0)
            else begin
                errors++;
                $error("[TB] FAIL sb_unexpected observed=%0h expected=none", word);
            end
            if (sb_q.size() > 0) begin
                logic [7:0] exp_w;
                exp_w = sb_q.pop_front();
                checks++;
                assert (word === exp_w)
                else begin
                    errors++;
                    $error("[TB] FAIL sb_word observed=%0h expected=%0h", word, exp_w);
                end
            end
        end
    end

    initial begin
        logic [7:0] hdr_bits;
        rstn       = 1'b1;
        d          = 1'b0;
        en         = 1'b0;
        clr_ovf    = 1'b0;
        word_ready = 1'b0;

        // Reset
        #2 rstn = 1'b0;
        #1;
        check_output("rst_word", word, 0);
        check_output("rst_valid", word_valid, 0);
        check_output("rst_ovf", overflow, 0);
        check_output("rst_busy", busy, 0);
        @(posedge clk);
        #1 rstn = 1'b1;

        // Basic frame 0xCA
        word_ready = 1'b1;
        sb_q.push_back(8'hCA);
        send_header();
        check_output("basic_busy", busy, 1);
        send_bits(8'hCA, 7, 1'b1);
        check_output("basic_early_valid", word_valid, 0);
        send_bits(8'hCA << 7, 1, 1'b1);
        check_output("basic_valid", word_valid, 1);
        check_output("basic_word", word, 8'hCA);
        check_output("basic_busy_end", busy, 0);
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
        check_output("basic_drained", word_valid, 0);

        // Enable gaps of 3 cycles between every bit
        sb_q.push_back(8'hCA);
        hdr_bits = 8'hB0;
        for (int i = 0; i < 12; i++) begin
            logic [7:0] src;
            src = (i < 4) ? hdr_bits : 8'hCA;
            apply_stimulus(src[(i < 4) ? 7 - i : 11 - i], 1'b1, 1'b1, 1'b0);
            if (i == 11) begin
                check_output("gap_valid", word_valid, 1);
                check_output("gap_word", word, 8'hCA);
            end else begin
                for (int g = 0; g < 3; g++) apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0);
            end
            if (i == 10) check_output("gap_no_spurious", word_valid, 0);
            if (i == 3) check_output("gap_busy", busy, 1);
        end
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);

        // Header hunt with a leading junk bit
        apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0);
        check_output("hunt_not_yet", busy, 0);
        apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0);
        check_output("hunt_match", busy, 1);
        sb_q.push_back(8'hFF);
        send_bits(8'hFF, 8, 1'b1);
        check_output("hunt_word", word, 8'hFF);
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);

        // Header split by an enable gap
        apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0);
        check_output("split_match", busy, 1);
        sb_q.push_back(8'h3C);
        send_bits(8'h3C, 8, 1'b1);
        check_output("split_word", word, 8'h3C);
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);

        // Backpressure and overflow
        word_ready = 1'b0;
        sb_q.push_back(8'h11);
        send_header();
        send_bits(8'h11, 8, 1'b0);
        check_output("bp_valid", word_valid, 1);
        check_output("bp_ovf0", overflow, 0);
        send_header();
        send_bits(8'h22, 8, 1'b0);
        check_output("bp_word_kept", word, 8'h11);
        check_output("bp_ovf1", overflow, 1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
        check_output("bp_clr", overflow, 0);
        send_header();
        send_bits(8'h44, 7, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1);
        check_output("bp_set_wins", overflow, 1);
        check_output("bp_word_kept2", word, 8'h11);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
        check_output("bp_clr2", overflow, 0);

        // Frame completes on the same edge as a transfer
        sb_q.push_back(8'h33);
        send_header();
        send_bits(8'h33, 7, 1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0);
        check_output("same_edge_word", word, 8'h33);
        check_output("same_edge_valid", word_valid, 1);
        check_output("same_edge_ovf", overflow, 0);
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
        check_output("same_edge_drained", word_valid, 0);

        // Mid-frame reset
        send_header();
        send_bits(8'hE0, 3, 1'b1);
        check_output("mid_busy_before", busy, 1);
        #2 rstn = 1'b0;
        #1;
        check_output("mid_busy", busy, 0);
        check_output("mid_valid", word_valid, 0);
        check_output("mid_word", word, 0);
        @(posedge clk);
        #1 rstn = 1'b1;
        sb_q.push_back(8'h5A);
        send_header();
        send_bits(8'h5A, 8, 1'b1);
        check_output("mid_after_word", word, 8'h5A);
        check_output("mid_after_valid", word_valid, 1);
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);

        check_output("sb_empty", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
